hsi_rx_msg_ctrl: RTL and testbench
==================================

// Module: hsi_rx_msg_ctrl
// PURPOSE
//  Receive-side message controller sitting directly behind the HSI byte decoder.
//  - Collects decoded bytes into a message buffer; frames messages on decoder msg_end.
//  - Discards messages with parity errors or overflow; recovers stalled links by resetting the decoder.
//  - Delivers each good message to the consumer byte by byte over a valid/ready stream.
// PARAMETERS
//  MAX_LEN   16   buffer depth in bytes; longest accepted message
//  LEN_W     5    width of length/pointer fields; must satisfy 2**LEN_W > MAX_LEN
//  TIMEOUT   255  clk_en ticks allowed between bytes inside a message before abort
// PORTS
//  clk          in   1      clock
//  n_rst        in   1      reset, asynchronous, active-low
//  clk_en       in   1      bit-rate tick shared with the decoder; all rx_* inputs sampled only when high
//  rx_byte      in   8      decoder data byte
//  rx_byte_rdy  in   1      decoder byte valid (parity good)
//  rx_pb_err    in   1      decoder parity error
//  rx_msg_end   in   1      decoder end-of-message
//  dec_n_rst    out  1      active-low reset to decoder; ANDed with n_rst at top level
//  msg_data     out  8      stream byte = buf[rd_ptr]
//  msg_valid    out  1      stream valid
//  msg_ready    in   1      stream ready from consumer
//  msg_last     out  1      high with final byte of message
//  msg_len      out  LEN_W  byte count of message being delivered
//  msg_err      out  1      one-clk pulse: message discarded
//  ovr_cnt      out  8      saturating count of bytes dropped while DELIVER busy
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset values (n_rst low):
//  - state=IDLE, wr_ptr=0, rd_ptr=0, tmo_cnt=0, msg_len=0, ovr_cnt=0.
//  - msg_valid=0, msg_last=0, msg_err=0, dec_n_rst=1, busy=0.
//  - Buffer contents are not reset.
//  Input sampling:
//  - rx_* inputs count only on clk edges with clk_en=1.
//  - Decoder strobes stay high for a full tick; one event is counted per tick.
//  States:
//  - IDLE:
//    - rx_byte_rdy: buf[0]<=rx_byte, wr_ptr=1, go RECV.
//    - rx_pb_err: go DISCARD.
//    - rx_msg_end alone: ignored (empty message).
//  - RECV:
//    - Each rx_byte_rdy writes buf[wr_ptr], increments wr_ptr, clears tmo_cnt.
//    - rx_byte_rdy while wr_ptr==MAX_LEN: overflow; byte dropped; go DISCARD.
//    - rx_pb_err: go DISCARD.
//    - rx_msg_end: msg_len<=wr_ptr (including a byte written in the same tick); rd_ptr<=0; go DELIVER.
//    - Each clk_en tick without a byte increments tmo_cnt.
//    - tmo_cnt reaching TIMEOUT: go RESYNC.
//  - DISCARD:
//    - Bytes are ignored until rx_msg_end.
//    - On rx_msg_end: msg_err pulses for 1 clk, wr_ptr<=0, go IDLE.
//    - pb_err together with msg_end in the same tick: pulse msg_err, go IDLE directly.
//    - The timeout applies in DISCARD as in RECV.
//  - RESYNC:
//    - dec_n_rst=0 for exactly one clk_en period.
//    - msg_err pulses on entry; wr_ptr<=0; then go IDLE.
//  - DELIVER:
//    - msg_valid=1; msg_data=buf[rd_ptr]; msg_last=(rd_ptr==msg_len-1).
//    - Transfer on clk edge with msg_valid & msg_ready; rd_ptr increments; not gated by clk_en.
//    - Transfer with msg_last: go IDLE next clk; msg_valid drops; wr_ptr<=0.
//    - msg_data, msg_last and msg_len stay stable while msg_valid=1 and msg_ready=0.
//    - rx_byte_rdy during DELIVER: byte dropped; ovr_cnt increments, saturating at 255.
//  Priority within a tick: overflow/pb_err > msg_end > timeout.
//  Latency:
//  - msg_valid rises on the clk after the tick that samples rx_msg_end.
//  - Back-to-back delivery is 1 byte/clk with msg_ready held high.
//  Reset mid-operation: everything returns to reset values; partial message is lost; no msg_err pulse.
// TESTING
//  - Bytes 0xA5,0x3C,0x7E then msg_end, ready=1 -> valid 3 clks, data A5,3C,7E, last on 7E, msg_len=3.
//  - Byte 0x11, pb_err, byte 0x22, msg_end -> no msg_valid; one msg_err pulse at msg_end tick; busy drops.
//  - 17 bytes then msg_end (MAX_LEN=16) -> discarded, msg_err=1 once, no delivery.
//  - Byte 0x55 then silence -> 255 ticks later dec_n_rst low one clk_en period, msg_err pulse, IDLE.
//  - 2-byte message, ready toggled 0,1,0,0,1 -> data held while stalled, both bytes delivered in order.
//  - 2 bytes arrive during stalled DELIVER -> ovr_cnt=2; delivered message unchanged.

Source files
------------

// File: rtl/hsi_rx_msg_if.sv
// Message stream from the receive controller to its consumer.
interface hsi_rx_msg_if #(
  parameter int LEN_W = 5
);
  logic [7:0]       msg_data;
  logic             msg_valid;
  logic             msg_ready;
  logic             msg_last;
  logic [LEN_W-1:0] msg_len;

  modport master (output msg_data, msg_valid, msg_last, msg_len, input  msg_ready);
  modport slave  (input  msg_data, msg_valid, msg_last, msg_len, output msg_ready);
endinterface

// File: rtl/hsi_rx_msg_ctrl.sv
// HSI receive message controller: frames decoded bytes into a buffer, drops
// bad or oversize messages, resets a stalled decoder, and streams good
// messages out one byte per clock.
module hsi_rx_msg_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clk_en,
  input  logic [7:0]       rx_byte,
  input  logic             rx_byte_rdy,
  input  logic             rx_pb_err,
  input  logic             rx_msg_end,
  output logic             dec_n_rst,
  hsi_rx_msg_if.master     msg,
  output logic             msg_err,
  output logic [7:0]       ovr_cnt,
  output logic             busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RECV, DISCARD, RESYNC, DELIVER} state_t;

  state_t           state;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0]    tmo_cnt;
  logic             valid_q;
  logic [7:0]       mem [MAX_LEN];

  logic             ovf;
  logic             we;
  logic [AW-1:0]    wa;
  logic             xfer;
  logic             last;
  logic             tmo_hit;

  // Buffer write decode and stream-side status
  always_comb begin
    ovf     = rx_byte_rdy && (wr_ptr == LEN_W'(MAX_LEN));
    we      = clk_en && rx_byte_rdy && !rx_pb_err &&
              ((state == IDLE) || (state == RECV && !ovf));
    wa      = (state == IDLE) ? '0 : wr_ptr[AW-1:0];
    last    = valid_q && (rd_ptr == len_q - LEN_W'(1));
    xfer    = valid_q && msg.msg_ready;
    tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  end

  assign msg.msg_data  = mem[rd_ptr[AW-1:0]];
  assign msg.msg_valid = valid_q;
  assign msg.msg_last  = last;
  assign msg.msg_len   = len_q;
  assign busy          = (state != IDLE);

  // Message buffer; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= rx_byte;
  end

  // Control FSM: receive/discard/resync run on clk_en ticks, delivery runs every clk
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len_q     <= '0;
      tmo_cnt   <= '0;
      valid_q   <= 1'b0;
      msg_err   <= 1'b0;
      dec_n_rst <= 1'b1;
      ovr_cnt   <= '0;
    end else begin
      msg_err <= 1'b0;
      if (state == DELIVER) begin
        if (xfer) begin
          rd_ptr <= rd_ptr + LEN_W'(1);
          if (last) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            wr_ptr  <= '0;
          end
        end
        if (clk_en && rx_byte_rdy && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end else if (clk_en) begin
        case (state)
          IDLE: begin
            tmo_cnt <= '0;
            if (rx_pb_err) begin
              // A bad byte that also ends the message is reported at once
              if (rx_msg_end) msg_err <= 1'b1;
              else            state   <= DISCARD;
            end else if (rx_byte_rdy) begin
              wr_ptr <= LEN_W'(1);
              if (rx_msg_end) begin
                len_q   <= LEN_W'(1);
                rd_ptr  <= '0;
                valid_q <= 1'b1;
                state   <= DELIVER;
              end else begin
                state <= RECV;
              end
            end
          end
          RECV: begin
            if (rx_pb_err || ovf) begin
              tmo_cnt <= '0;
              if (rx_msg_end) begin
                msg_err <= 1'b1;
                wr_ptr  <= '0;
                state   <= IDLE;
              end else begin
                state <= DISCARD;
              end
            end else if (rx_msg_end) begin
              len_q   <= rx_byte_rdy ? wr_ptr + LEN_W'(1) : wr_ptr;
              rd_ptr  <= '0;
              valid_q <= 1'b1;
              state   <= DELIVER;
            end else if (rx_byte_rdy) begin
              wr_ptr  <= wr_ptr + LEN_W'(1);
              tmo_cnt <= '0;
            end else if (tmo_hit) begin
              tmo_cnt   <= '0;
              wr_ptr    <= '0;
              msg_err   <= 1'b1;
              dec_n_rst <= 1'b0;
              state     <= RESYNC;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          DISCARD: begin
            if (rx_msg_end) begin
              msg_err <= 1'b1;
              wr_ptr  <= '0;
              tmo_cnt <= '0;
              state   <= IDLE;
            end else if (rx_byte_rdy) begin
              tmo_cnt <= '0;
            end else if (tmo_hit) begin
              tmo_cnt   <= '0;
              wr_ptr    <= '0;
              msg_err   <= 1'b1;
              dec_n_rst <= 1'b0;
              state     <= RESYNC;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          RESYNC: begin
            // Decoder reset has been held for one full tick period
            dec_n_rst <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsi_rx_msg_ctrl.sv
// Directed bench for hsi_rx_msg_ctrl with hand-computed expectations.
module tb_hsi_rx_msg_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clk_en;
  logic [7:0] rx_byte;
  logic       rx_byte_rdy;
  logic       rx_pb_err;
  logic       rx_msg_end;
  logic       dec_n_rst;
  logic       msg_err;
  logic [7:0] ovr_cnt;
  logic       busy;

  int vecs = 0;
  int errs = 0;

  hsi_rx_msg_if #(.LEN_W(5)) msg ();

  hsi_rx_msg_ctrl #(.MAX_LEN(16), .LEN_W(5), .TIMEOUT(255)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clk_en      (clk_en),
    .rx_byte     (rx_byte),
    .rx_byte_rdy (rx_byte_rdy),
    .rx_pb_err   (rx_pb_err),
    .rx_msg_end  (rx_msg_end),
    .dec_n_rst   (dec_n_rst),
    .msg         (msg),
    .msg_err     (msg_err),
    .ovr_cnt     (ovr_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one tick's worth of decoder strobes, then sample 1 time unit after the edge
  task automatic step(input logic rdy, input logic [7:0] b, input logic pb, input logic me);
    rx_byte_rdy = rdy;
    rx_byte     = b;
    rx_pb_err   = pb;
    rx_msg_end  = me;
    @(posedge clk);
    #1;
    rx_byte_rdy = 1'b0;
    rx_pb_err   = 1'b0;
    rx_msg_end  = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; clk_en = 1'b1; rx_byte = '0;
    rx_byte_rdy = 1'b0; rx_pb_err = 1'b0; rx_msg_end = 1'b0;
    msg.msg_ready = 1'b0;
    #12;
    chk("rst_busy",  busy, 0);
    chk("rst_valid", msg.msg_valid, 0);
    chk("rst_last",  msg.msg_last, 0);
    chk("rst_err",   msg_err, 0);
    chk("rst_dec",   dec_n_rst, 1);
    chk("rst_len",   msg.msg_len, 0);
    chk("rst_ovr",   ovr_cnt, 0);
    n_rst = 1'b1;

    // Strobes without clk_en are not sampled
    clk_en = 1'b0;
    step(1, 8'h99, 0, 0);
    chk("noen_busy", busy, 0);
    clk_en = 1'b1;

    // Three-byte message, consumer always ready
    msg.msg_ready = 1'b1;
    step(1, 8'hA5, 0, 0);
    chk("m1_busy", busy, 1);
    step(1, 8'h3C, 0, 0);
    step(1, 8'h7E, 0, 0);
    chk("m1_nv", msg.msg_valid, 0);
    step(0, 8'h00, 0, 1);
    chk("m1_v0", msg.msg_valid, 1);
    chk("m1_d0", msg.msg_data, 8'hA5);
    chk("m1_l0", msg.msg_last, 0);
    chk("m1_len", msg.msg_len, 3);
    step(0, 8'h00, 0, 0);
    chk("m1_d1", msg.msg_data, 8'h3C);
    chk("m1_l1", msg.msg_last, 0);
    step(0, 8'h00, 0, 0);
    chk("m1_d2", msg.msg_data, 8'h7E);
    chk("m1_l2", msg.msg_last, 1);
    chk("m1_v2", msg.msg_valid, 1);
    step(0, 8'h00, 0, 0);
    chk("m1_vend", msg.msg_valid, 0);
    chk("m1_idle", busy, 0);

    // Parity error mid-message: discarded, one error pulse at msg_end
    step(1, 8'h11, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("pb_busy", busy, 1);
    chk("pb_err0", msg_err, 0);
    step(1, 8'h22, 0, 0);
    chk("pb_nv", msg.msg_valid, 0);
    step(0, 8'h00, 0, 1);
    chk("pb_err1", msg_err, 1);
    chk("pb_idle", busy, 0);
    chk("pb_nv2", msg.msg_valid, 0);
    step(0, 8'h00, 0, 0);
    chk("pb_err2", msg_err, 0);
    chk("pb_nv3", msg.msg_valid, 0);

    // Seventeen bytes overflow a 16-byte buffer
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("ov_busy", busy, 1);
    step(1, 8'hF0, 0, 0);
    chk("ov_err0", msg_err, 0);
    chk("ov_busy2", busy, 1);
    step(0, 8'h00, 0, 1);
    chk("ov_err1", msg_err, 1);
    chk("ov_nv", msg.msg_valid, 0);
    chk("ov_idle", busy, 0);
    step(0, 8'h00, 0, 0);
    chk("ov_err2", msg_err, 0);
    chk("ov_nv2", msg.msg_valid, 0);

    // One byte then silence: decoder reset after 255 empty ticks
    step(1, 8'h55, 0, 0);
    repeat (254) step(0, 8'h00, 0, 0);
    chk("to_dec_hi", dec_n_rst, 1);
    chk("to_busy", busy, 1);
    chk("to_err0", msg_err, 0);
    step(0, 8'h00, 0, 0);
    chk("to_dec_lo", dec_n_rst, 0);
    chk("to_err1", msg_err, 1);
    clk_en = 1'b0;
    step(0, 8'h00, 0, 0);
    chk("to_dec_hold", dec_n_rst, 0);
    chk("to_err2", msg_err, 0);
    chk("to_busy2", busy, 1);
    clk_en = 1'b1;
    step(0, 8'h00, 0, 0);
    chk("to_dec_rel", dec_n_rst, 1);
    chk("to_idle", busy, 0);

    // Two-byte message with ready pattern 0,1,0,0,1
    msg.msg_ready = 1'b0;
    step(1, 8'h81, 0, 0);
    step(1, 8'h42, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("st_v", msg.msg_valid, 1);
    chk("st_d0", msg.msg_data, 8'h81);
    chk("st_len", msg.msg_len, 2);
    step(0, 8'h00, 0, 0);
    chk("st_hold0", msg.msg_data, 8'h81);
    chk("st_l0", msg.msg_last, 0);
    msg.msg_ready = 1'b1;
    step(0, 8'h00, 0, 0);
    chk("st_d1", msg.msg_data, 8'h42);
    chk("st_l1", msg.msg_last, 1);
    msg.msg_ready = 1'b0;
    step(0, 8'h00, 0, 0);
    chk("st_hold1", msg.msg_data, 8'h42);
    step(0, 8'h00, 0, 0);
    chk("st_hold2", msg.msg_data, 8'h42);
    chk("st_l2", msg.msg_last, 1);
    chk("st_v2", msg.msg_valid, 1);
    chk("st_len2", msg.msg_len, 2);
    msg.msg_ready = 1'b1;
    step(0, 8'h00, 0, 0);
    chk("st_vend", msg.msg_valid, 0);

    // Bytes arriving during a stalled delivery are dropped and counted
    msg.msg_ready = 1'b0;
    step(1, 8'h9A, 0, 0);
    step(1, 8'hB7, 0, 1);
    chk("dr_len", msg.msg_len, 2);
    step(1, 8'hEE, 0, 0);
    chk("dr_ovr1", ovr_cnt, 1);
    step(1, 8'hFF, 0, 0);
    chk("dr_ovr2", ovr_cnt, 2);
    chk("dr_d0", msg.msg_data, 8'h9A);
    msg.msg_ready = 1'b1;
    step(0, 8'h00, 0, 0);
    chk("dr_d1", msg.msg_data, 8'hB7);
    chk("dr_l1", msg.msg_last, 1);
    step(0, 8'h00, 0, 0);
    chk("dr_vend", msg.msg_valid, 0);
    chk("dr_idle", busy, 0);
    chk("dr_ovr", ovr_cnt, 2);

    // Asynchronous reset mid-message
    step(1, 8'h10, 0, 0);
    chk("ar_busy", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("ar_busy0", busy, 0);
    chk("ar_ovr0", ovr_cnt, 0);
    chk("ar_err0", msg_err, 0);
    chk("ar_len0", msg.msg_len, 0);
    n_rst = 1'b1;
    step(0, 8'h00, 0, 1);
    chk("ar_nv", msg.msg_valid, 0);
    chk("ar_noerr", msg_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
